// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI4 read port between fetch (M0) and load (M1) masters
// Ports: clk/rst (async, active-high); m0_*/m1_* AR and R channels of the two masters;
// s_* AR and R channels towards the memory slave. One burst outstanding at a time.
module axi_read_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t r_state, w_next;
  logic r_grant, r_last_grant;
  logic w_req, w_pick, w_r_done;
  assign w_req = m0_arvalid | m1_arvalid;
  // On a tie, round-robin hands the port to whoever was not served last.
  assign w_pick = (m0_arvalid & m1_arvalid) ? ((FIXED_PRI != 0) ? 1'b0 : ~r_last_grant) : m1_arvalid;
  assign w_r_done = (r_state == DATA) & s_rvalid & s_rready & s_rlast;
  assign s_araddr  = r_grant ? m1_araddr  : m0_araddr;
  assign s_arlen   = r_grant ? m1_arlen   : m0_arlen;
  assign s_arsize  = r_grant ? m1_arsize  : m0_arsize;
  assign s_arburst = r_grant ? m1_arburst : m0_arburst;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rlast  = s_rlast;
  assign m1_rlast  = s_rlast;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) r_grant <= w_pick;
      if (w_r_done) r_last_grant <= r_grant;
    end
  end
  always_comb begin
    w_next     = r_state;
    s_arvalid  = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    if (r_state == IDLE) begin
      if (w_req) w_next = ADDR;
    end else if (r_state == ADDR) begin
      s_arvalid  = 1'b1;
      m0_arready = ~r_grant & s_arready;
      m1_arready = r_grant & s_arready;
      if (s_arready) w_next = DATA;
    end else if (r_state == DATA) begin
      s_rready  = r_grant ? m1_rready : m0_rready;
      m0_rvalid = ~r_grant & s_rvalid;
      m1_rvalid = r_grant & s_rvalid;
      if (w_r_done) w_next = IDLE;
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: randomized scoreboard bench for the two-master read arbiter
module tb_axi_read_arbiter;
  typedef struct packed {
    logic        g;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;
  req_t q[$];
  logic clk = 1'b0, rst = 1'b0;
  bit pause = 1'b1, gen_en = 1'b0, m_free = 1'b1, mon_act = 1'b0;
  int mon_beat = 0, mon_len = 0, tests = 0, fails = 0;
  logic [31:0] ar_addr[2];
  logic [7:0]  ar_len[2];
  logic [2:0]  ar_size[2];
  logic [1:0]  ar_burst[2];
  logic [1:0]  arv, arr, rv, rr, rl;
  logic [31:0] rd0, rd1;
  logic [31:0] s_araddr, s_rdata;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [1:0]  f_arv, f_arr, f_rv, f_rl;
  logic [31:0] f_rd0, f_rd1, f_s_araddr;
  logic [7:0]  f_s_arlen;
  logic [2:0]  f_s_arsize;
  logic [1:0]  f_s_arburst;
  logic        f_s_arvalid, f_s_rready;
  always #5 clk = ~clk;
  axi_read_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(0)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(ar_addr[0]), .m0_arlen(ar_len[0]), .m0_arsize(ar_size[0]), .m0_arburst(ar_burst[0]),
    .m0_arvalid(arv[0]), .m0_arready(arr[0]), .m0_rdata(rd0), .m0_rlast(rl[0]), .m0_rvalid(rv[0]), .m0_rready(rr[0]),
    .m1_araddr(ar_addr[1]), .m1_arlen(ar_len[1]), .m1_arsize(ar_size[1]), .m1_arburst(ar_burst[1]),
    .m1_arvalid(arv[1]), .m1_arready(arr[1]), .m1_rdata(rd1), .m1_rlast(rl[1]), .m1_rvalid(rv[1]), .m1_rready(rr[1]),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );
  axi_read_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(1)) dut_fix (
    .clk(clk), .rst(rst),
    .m0_araddr(ar_addr[0]), .m0_arlen(ar_len[0]), .m0_arsize(ar_size[0]), .m0_arburst(ar_burst[0]),
    .m0_arvalid(f_arv[0]), .m0_arready(f_arr[0]), .m0_rdata(f_rd0), .m0_rlast(f_rl[0]), .m0_rvalid(f_rv[0]), .m0_rready(1'b1),
    .m1_araddr(ar_addr[1]), .m1_arlen(ar_len[1]), .m1_arsize(ar_size[1]), .m1_arburst(ar_burst[1]),
    .m1_arvalid(f_arv[1]), .m1_arready(f_arr[1]), .m1_rdata(f_rd1), .m1_rlast(f_rl[1]), .m1_rvalid(f_rv[1]), .m1_rready(1'b1),
    .s_araddr(f_s_araddr), .s_arlen(f_s_arlen), .s_arsize(f_s_arsize), .s_arburst(f_s_arburst),
    .s_arvalid(f_s_arvalid), .s_arready(1'b1), .s_rdata(32'h0), .s_rlast(1'b1),
    .s_rvalid(1'b1), .s_rready(f_s_rready)
  );
  function automatic logic [31:0] beat_data(logic [31:0] a, int b);
    return (a + 32'(b) * 32'd4) ^ 32'hC0DE0000;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // Masters and a memory slave; the slave keeps a beat stable until accepted.
  initial begin : drv
    logic [1:0]  hs_m;
    bit          hs_ar, hs_r, sl_act;
    logic [31:0] sl_addr;
    logic [7:0]  sl_len, sl_beat;
    hs_m = 0; hs_ar = 0; hs_r = 0; sl_act = 0; sl_addr = 0; sl_len = 0; sl_beat = 0;
    forever begin
      @(negedge clk);
      if (pause) begin
        for (int i = 0; i < 2; i++) begin
          ar_addr[i]  = $urandom & 32'hFFFF_FFFC;
          ar_len[i]   = 8'($urandom_range(0, 7));
          ar_size[i]  = 3'($urandom_range(0, 7));
          ar_burst[i] = 2'($urandom_range(0, 3));
        end
        arv = 2'b11; rr = 2'b11; s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = 0;
        sl_act = 0; hs_m = 0; hs_ar = 0; hs_r = 0;
        continue;
      end
      if (hs_r && sl_act) begin
        if (sl_beat == sl_len) sl_act = 0;
        else sl_beat++;
      end
      if (hs_ar) begin
        sl_act = 1;
        sl_beat = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (hs_m[i]) arv[i] = 1'b0;
        if (!arv[i] && gen_en && $urandom_range(0, 3) == 0) begin
          arv[i]      = 1'b1;
          ar_addr[i]  = $urandom & 32'hFFFF_FFFC;
          ar_len[i]   = 8'($urandom_range(0, 7));
          ar_size[i]  = 3'($urandom_range(0, 7));
          ar_burst[i] = 2'($urandom_range(0, 3));
        end
        rr[i] = $urandom_range(0, 3) != 0;
      end
      s_arready = 1'($urandom_range(0, 1));
      if (sl_act) begin
        if (hs_r || !s_rvalid) s_rvalid = $urandom_range(0, 2) != 0;
        s_rdata = beat_data(sl_addr, int'(sl_beat));
        s_rlast = sl_beat == sl_len;
      end else begin
        s_rvalid = $urandom_range(0, 4) == 0;
        s_rdata  = $urandom;
        s_rlast  = 1'($urandom_range(0, 1));
      end
      #1;
      hs_m  = arv & arr;
      hs_ar = s_arvalid && s_arready;
      hs_r  = s_rvalid && s_rready;
      if (hs_ar) begin
        sl_addr = s_araddr;
        sl_len  = s_arlen;
      end
    end
  end
  // Reference: one burst at a time; a free port serves a lone requester,
  // and on a tie the master not served last. The winner's AR is due next cycle.
  initial begin : model
    bit last, exp_arv;
    logic g;
    last = 1; exp_arv = 0;
    forever begin
      @(negedge clk);
      #2;
      if (pause) begin
        m_free = 1; last = 1; exp_arv = 0;
        continue;
      end
      if (exp_arv) chk("ar_latency", s_arvalid, 1);
      exp_arv = 0;
      if (m_free) begin
        chk("idle_quiet", {s_arvalid, s_rready, arr, rv}, 0);
        if (arv != 0) begin
          g = (arv == 2'b11) ? ~last : arv[1];
          q.push_back(req_t'{g, ar_addr[g], ar_len[g], ar_size[g], ar_burst[g]});
          last = g;
          m_free = 0;
          exp_arv = 1;
        end
      end else if (s_rvalid && s_rready && s_rlast) m_free = 1;
    end
  end
  initial begin : mon
    req_t cur;
    cur = '0;
    forever begin
      @(negedge clk);
      #3;
      if (pause) begin
        q.delete();
        mon_act = 0;
        continue;
      end
      if (mon_act) begin
        chk("rvalid_route", rv, s_rvalid ? (2'b01 << cur.g) : 2'b00);
        chk("rready_route", s_rready, rr[cur.g]);
        if (s_rvalid && s_rready) begin
          chk("rdata", cur.g ? rd1 : rd0, beat_data(cur.addr, mon_beat));
          chk("rlast", rl[cur.g], mon_beat == mon_len);
          if (mon_beat == mon_len) mon_act = 0;
          else mon_beat++;
        end
      end else chk("r_quiet", {rv, s_rready}, 0);
      if (s_arvalid && s_arready) begin
        if (q.size() == 0) chk("unexpected_ar", 1, 0);
        else begin
          cur = q.pop_front();
          chk("ar_addr", s_araddr, cur.addr);
          chk("ar_len", s_arlen, cur.len);
          chk("ar_size_burst", {s_arsize, s_arburst}, {cur.size, cur.burst});
          chk("arready_route", arr, 2'b01 << cur.g);
          mon_act = 1;
          mon_beat = 0;
          mon_len = int'(cur.len);
        end
      end else chk("arready_idle", arr, 0);
    end
  end
  task automatic drain();
    int i;
    for (i = 0; i < 1000; i++) begin
      if (q.size() == 0 && !mon_act && arv == 0 && m_free) break;
      @(negedge clk);
    end
    chk("drain", i < 1000, 1);
  endtask
  initial begin
    int n, i;
    bit drop;
    f_arv = 2'b00;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ar", {s_arvalid, arr}, 0);
    chk("rst_r", {s_rready, rv}, 0);
    chk("rst_fix", {f_s_arvalid, f_arr, f_s_rready, f_rv}, 0);
    @(negedge clk);
    rst = 1'b0; pause = 1'b0; gen_en = 1'b1;
    repeat (3000) @(negedge clk);
    gen_en = 1'b0;
    drain();
    gen_en = 1'b1;
    for (i = 0; i < 2000 && !(mon_act && mon_beat >= 1 && mon_beat < mon_len); i++) @(negedge clk);
    chk("midburst_found", i < 2000, 1);
    @(posedge clk);
    #1 rst = 1'b1; pause = 1'b1;
    #1 chk("async_rst", {s_rready, rv, s_arvalid, arr}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; pause = 1'b0;
    repeat (1000) @(negedge clk);
    gen_en = 1'b0;
    drain();
    n = 0; drop = 0;
    f_arv = 2'b11;
    for (i = 0; i < 200 && n < 5; i++) begin
      @(negedge clk);
      if (drop) f_arv = 2'b10;
      #1;
      if (f_s_arvalid) begin
        n++;
        chk("fixed_grant", f_arr, n <= 4 ? 2'b01 : 2'b10);
        chk("fixed_addr", f_s_araddr, n <= 4 ? ar_addr[0] : ar_addr[1]);
        if (n == 4) drop = 1;
      end
    end
    chk("fixed_count", n, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
